// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce_toggle_bank push-button front end.
package debounce_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int HOLD_CYCLES_DEF     = 5000000;

    // Counter width for a terminal count of n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_toggle_bank_if.sv
// Switch/LED bus between the board-facing debounce bank and its consumer.
interface debounce_toggle_bank_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] i_switch;
    logic              i_led_clr;
    logic [NUM_CH-1:0] o_switch;
    logic [NUM_CH-1:0] o_press;
    logic [NUM_CH-1:0] o_release;
    logic [NUM_CH-1:0] o_long;
    logic [NUM_CH-1:0] o_led;

    modport master (
        output i_switch, i_led_clr,
        input  o_switch, o_press, o_release, o_long, o_led
    );

    modport slave (
        input  i_switch, i_led_clr,
        output o_switch, o_press, o_release, o_long, o_led
    );
endinterface

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, counter debounce, press/release pulses, toggle LED.
// Long-press detection is built only when LONG_PRESS_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_switch,
    input  logic i_led_clr,
    output logic o_switch,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_led
);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_bad_params
        $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2 and HOLD_CYCLES >= 1");
    end

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          flip;
    logic          fall;
    logic          suppress;

    assign flip = (s2 != o_switch) && (cnt == CNT_LAST);
    assign fall = flip && !s2;

    // NOTE: every flop here is cleared by a synchronous reset and written with <=,
    // so all state updates on the same edge from pre-edge values.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= i_switch;
            s2 <= s1;
        end
    end

    // Any cycle where the synchronised input agrees with the debounced state restarts the count.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (s2 == o_switch || flip) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_switch  <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_switch  <= flip ? s2 : o_switch;
            o_press   <= flip && s2;
            o_release <= fall;
        end
    end

`ifdef LONG_PRESS_EN
    localparam int            HW       = cnt_width(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_HIT = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] hold_cnt;
    logic          long_flag;
    logic          long_hit;

    // A hold that would qualify on the release edge itself is treated as a short press.
    assign long_hit = o_switch && !flip && (hold_cnt == HOLD_HIT);
    assign suppress = long_flag;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            hold_cnt  <= '0;
            long_flag <= 1'b0;
            o_long    <= 1'b0;
        end else begin
            if (!o_switch) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            o_long <= long_hit;
            if (fall) begin
                long_flag <= 1'b0;
            end else if (long_hit) begin
                long_flag <= 1'b1;
            end
        end
    end
`else
    assign o_long   = 1'b0;
    assign suppress = 1'b0;
`endif

    // Clear takes priority over a toggle landing on the same edge.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_led <= 1'b0;
        end else if (i_led_clr) begin
            o_led <= 1'b0;
        end else if (fall && !suppress) begin
            o_led <= ~o_led;
        end
    end

endmodule

// File: rtl/debounce_toggle_bank.sv
// Multi-channel push-button front end: NUM_CH independent debounce_channel instances.
// Optional long-press suppression of the release toggle: define LONG_PRESS_EN.
module debounce_toggle_bank
    import debounce_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    i_rst,
    debounce_toggle_bank_if.slave   bus
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_ch (
            .clk       (clk),
            .i_rst     (i_rst),
            .i_switch  (bus.i_switch[c]),
            .i_led_clr (bus.i_led_clr),
            .o_switch  (bus.o_switch[c]),
            .o_press   (bus.o_press[c]),
            .o_release (bus.o_release[c]),
            .o_long    (bus.o_long[c]),
            .o_led     (bus.o_led[c])
        );
    end

endmodule
